// File: rtl/mips_io_pkg.sv
// Shared types and defaults for the board input conditioning path.
package mips_io_pkg;

   localparam int unsigned SW_WIDTH_DEFAULT        = 10;
   localparam int unsigned BTN_WIDTH_DEFAULT       = 2;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

   // Debounce FSM: the two *_WAIT states hold the previous accepted level
   // while the new input level proves itself stable.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } debounce_state_t;

endpackage : mips_io_pkg

// File: rtl/board_input_conditioner_if.sv
// Board-pin side bundle: raw pins in, conditioned levels/pulses out.
interface board_input_conditioner_if
   import mips_io_pkg::*;
#(
   parameter int unsigned SW_WIDTH  = SW_WIDTH_DEFAULT,
   parameter int unsigned BTN_WIDTH = BTN_WIDTH_DEFAULT
) ();

   logic [BTN_WIDTH-1:0] buttons_raw;
   logic [SW_WIDTH-1:0]  switches_raw;
   logic [BTN_WIDTH-1:0] btn_level;
   logic [BTN_WIDTH-1:0] btn_pulse;
   logic [SW_WIDTH-1:0]  sw_sync;

   // Board / stimulus side: drives the pins, observes conditioned outputs.
   modport master (
      output buttons_raw,
      output switches_raw,
      input  btn_level,
      input  btn_pulse,
      input  sw_sync
   );

   // Conditioner side.
   modport slave (
      input  buttons_raw,
      input  switches_raw,
      output btn_level,
      output btn_pulse,
      output sw_sync
   );

endinterface : board_input_conditioner_if

// File: rtl/button_debounce.sv
// One push button: 2-flop synchronizer, polarity normalization, debounce FSM.
module button_debounce
   import mips_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic button_raw,
   output logic level,
   output logic pulse
);

   localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic            IDLE_PIN = ACTIVE_LOW;

   logic            sync_meta;
   logic            sync_q;
   logic            active_c;
   debounce_state_t state;
   debounce_state_t state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic            level_next;
   logic            pulse_next;

   // Synchronizer resets to the released pin value so reset never looks like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_meta <= IDLE_PIN;
         sync_q    <= IDLE_PIN;
      end else begin
         sync_meta <= button_raw;
         sync_q    <= sync_meta;
      end
   end

   assign active_c = sync_q ^ ACTIVE_LOW;

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         level <= level_next;
         pulse <= pulse_next;
      end
   end

   // Next state: counter clears on every state change, so it never wraps.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      pulse_next = 1'b0;
      level_next = 1'b0;

      case (state)
         IDLE: begin
            if (active_c) begin
               state_next = PRESS_WAIT;
               cnt_next   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!active_c) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = PRESSED;
               cnt_next   = '0;
               pulse_next = 1'b1;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (!active_c) begin
               state_next = RELEASE_WAIT;
               cnt_next   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (active_c) begin
               state_next = PRESSED;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);
   end

endmodule : button_debounce

// File: rtl/board_input_conditioner.sv
// Synchronizes slide switches and debounces push buttons ahead of the MIPS top level.
module board_input_conditioner
   import mips_io_pkg::*;
#(
   parameter int unsigned SW_WIDTH        = SW_WIDTH_DEFAULT,
   parameter int unsigned BTN_WIDTH       = BTN_WIDTH_DEFAULT,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   board_input_conditioner_if.slave  io
);

   logic [SW_WIDTH-1:0]  sw_meta;
   logic [SW_WIDTH-1:0]  sw_q;
   logic [BTN_WIDTH-1:0] level;
   logic [BTN_WIDTH-1:0] pulse;

   // Switches only need metastability protection, no debounce.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_meta <= '0;
         sw_q    <= '0;
      end else begin
         sw_meta <= io.switches_raw;
         sw_q    <= sw_meta;
      end
   end

   assign io.sw_sync = sw_q;

   // Buttons are fully independent; one debouncer each.
   for (genvar i = 0; i < int'(BTN_WIDTH); i++) begin : g_btn
      button_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (BTN_ACTIVE_LOW)
      ) u_debounce (
         .clk        (clk),
         .rst        (rst),
         .button_raw (io.buttons_raw[i]),
         .level      (level[i]),
         .pulse      (pulse[i])
      );
   end

   assign io.btn_level = level;
   assign io.btn_pulse = pulse;

endmodule : board_input_conditioner

// File: tb/tb_board_input_conditioner.sv
// Randomized self-checking bench for board_input_conditioner (DEBOUNCE_CYCLES=4, active-low buttons).
module tb_board_input_conditioner;

   localparam int unsigned SW_W  = 10;
   localparam int unsigned BTN_W = 2;
   localparam int unsigned DEB   = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   board_input_conditioner_if #(.SW_WIDTH(SW_W), .BTN_WIDTH(BTN_W)) io ();

   board_input_conditioner #(
      .SW_WIDTH        (SW_W),
      .BTN_WIDTH       (BTN_W),
      .DEBOUNCE_CYCLES (DEB),
      .BTN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io.slave)
   );

   // Reference model: a level is accepted once the input seen by the debouncer
   // (raw pin delayed two edges) has disagreed with it for DEB+1 consecutive edges.
   logic [BTN_W-1:0] m_b1 = 2'b11;
   logic [BTN_W-1:0] m_b2 = 2'b11;
   logic [SW_W-1:0]  m_s1 = '0;
   logic [SW_W-1:0]  m_sw = '0;
   logic [BTN_W-1:0] m_level = '0;
   logic [BTN_W-1:0] m_pulse = '0;
   int               m_run [BTN_W];

   always @(posedge clk or negedge rst) begin
      logic [BTN_W-1:0] seen;
      logic             act;
      if (!rst) begin
         m_b1 = 2'b11; m_b2 = 2'b11; m_s1 = '0; m_sw = '0;
         m_level = '0; m_pulse = '0;
         for (int i = 0; i < int'(BTN_W); i++) m_run[i] = 0;
      end else begin
         seen = m_b2;
         m_b2 = m_b1;
         m_b1 = io.buttons_raw;
         m_sw = m_s1;
         m_s1 = io.switches_raw;
         for (int i = 0; i < int'(BTN_W); i++) begin
            act = ~seen[i];
            m_pulse[i] = 1'b0;
            if (act !== m_level[i]) m_run[i] = m_run[i] + 1;
            else m_run[i] = 0;
            if (m_run[i] == int'(DEB) + 1) begin
               m_level[i] = act;
               m_pulse[i] = act;
               m_run[i]   = 0;
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         io.buttons_raw  = BTN_W'($urandom);
         io.switches_raw = SW_W'($urandom);
         @(negedge clk);
         checks++;
         if (io.btn_level !== 2'b00 || io.btn_pulse !== 2'b00 || io.sw_sync !== 10'h000) begin
            failures++;
            $display("FAIL reset_hold cyc=%0d got lvl=%b pls=%b sw=%h want 0", c, io.btn_level, io.btn_pulse, io.sw_sync);
         end
      end
      io.buttons_raw  = 2'b11;
      io.switches_raw = '0;
      rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (io.btn_level !== 2'b00 || io.btn_pulse !== 2'b00 || io.sw_sync !== 10'h000) begin
            failures++;
            $display("FAIL reset_release cyc=%0d got lvl=%b pls=%b sw=%h want 0", c, io.btn_level, io.btn_pulse, io.sw_sync);
         end
      end
   endtask

   task automatic test_clean_press();
      int pulses = 0;
      io.buttons_raw[0] = 1'b0;
      for (int c = 0; c < 56; c++) begin
         @(negedge clk);
         checks++;
         if (io.btn_level !== m_level || io.btn_pulse !== m_pulse) begin
            failures++;
            $display("FAIL press_model cyc=%0d got lvl=%b pls=%b want lvl=%b pls=%b", c, io.btn_level, io.btn_pulse, m_level, m_pulse);
         end
         if (io.btn_pulse[0]) pulses++;
         if (c == 5 || c == 6 || c == 7) begin
            checks++;
            if (io.btn_level[0] !== (c >= 6) || io.btn_pulse[0] !== (c == 6)) begin
               failures++;
               $display("FAIL press_timing edge=%0d got lvl=%b pls=%b want lvl=%b pls=%b", c, io.btn_level[0], io.btn_pulse[0], c >= 6, c == 6);
            end
         end
      end
      checks++;
      if (pulses != 1 || io.btn_level[0] !== 1'b1) begin
         failures++;
         $display("FAIL press_hold got pulses=%0d lvl=%b want pulses=1 lvl=1", pulses, io.btn_level[0]);
      end
      io.buttons_raw[0] = 1'b1;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (io.btn_pulse[0]) pulses++;
         if (c == 5 || c == 6) begin
            checks++;
            if (io.btn_level[0] !== (c == 5)) begin
               failures++;
               $display("FAIL release_timing edge=%0d got lvl=%b want %b", c, io.btn_level[0], c == 5);
            end
         end
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL release_pulse got pulses=%0d want 0", pulses);
      end
   endtask

   task automatic test_bounce();
      int pulses = 0;
      int falls  = 0;
      logic prev;
      for (int k = 0; k < 10; k++) begin
         io.buttons_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
         repeat (2) begin
            @(negedge clk);
            checks++;
            if (io.btn_level !== m_level || io.btn_pulse !== m_pulse) begin
               failures++;
               $display("FAIL bounce_press_model k=%0d got lvl=%b pls=%b want lvl=%b pls=%b", k, io.btn_level, io.btn_pulse, m_level, m_pulse);
            end
            if (io.btn_pulse[1]) pulses++;
         end
      end
      io.buttons_raw[1] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (io.btn_pulse[1]) pulses++;
         checks++;
         if (io.btn_pulse[1] !== (c == 6) || io.btn_level[1] !== (c >= 6)) begin
            failures++;
            $display("FAIL bounce_press edge=%0d got lvl=%b pls=%b want lvl=%b pls=%b", c, io.btn_level[1], io.btn_pulse[1], c >= 6, c == 6);
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL bounce_press_count got pulses=%0d want 1", pulses);
      end
      pulses = 0;
      prev = io.btn_level[1];
      for (int k = 0; k < 11; k++) begin
         io.buttons_raw[1] = (k == 10) ? 1'b1 : ((k % 2 == 0) ? 1'b1 : 1'b0);
         repeat ((k == 10) ? 12 : 2) begin
            @(negedge clk);
            checks++;
            if (io.btn_level !== m_level || io.btn_pulse !== m_pulse) begin
               failures++;
               $display("FAIL bounce_release_model k=%0d got lvl=%b pls=%b want lvl=%b pls=%b", k, io.btn_level, io.btn_pulse, m_level, m_pulse);
            end
            if (io.btn_pulse[1]) pulses++;
            if (prev && !io.btn_level[1]) falls++;
            prev = io.btn_level[1];
         end
      end
      checks++;
      if (falls != 1 || pulses != 0 || io.btn_level[1] !== 1'b0) begin
         failures++;
         $display("FAIL bounce_release got falls=%0d pulses=%0d lvl=%b want falls=1 pulses=0 lvl=0", falls, pulses, io.btn_level[1]);
      end
   endtask

   task automatic test_glitch();
      int len;
      for (int t = 0; t < 4; t++) begin
         len = (t == 0) ? 3 : int'($urandom_range(1, DEB - 1));
         io.buttons_raw[0] = 1'b0;
         repeat (len) @(negedge clk);
         io.buttons_raw[0] = 1'b1;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (io.btn_level[0] !== 1'b0 || io.btn_pulse[0] !== 1'b0 || io.btn_level !== m_level) begin
               failures++;
               $display("FAIL glitch len=%0d cyc=%0d got lvl=%b pls=%b want lvl=0 pls=0", len, c, io.btn_level, io.btn_pulse);
            end
         end
      end
   endtask

   task automatic test_switches();
      logic [SW_W-1:0] val;
      io.switches_raw = 10'h2A5;
      @(negedge clk);
      checks++;
      if (io.sw_sync !== 10'h000) begin
         failures++;
         $display("FAIL sw_edge0 got %h want 000", io.sw_sync);
      end
      @(negedge clk);
      checks++;
      if (io.sw_sync !== 10'h2A5) begin
         failures++;
         $display("FAIL sw_edge1 got %h want 2a5", io.sw_sync);
      end
      for (int t = 0; t < 6; t++) begin
         val = SW_W'($urandom);
         io.switches_raw = val;
         repeat (2) @(negedge clk);
         checks++;
         if (io.sw_sync !== val || io.sw_sync !== m_sw) begin
            failures++;
            $display("FAIL sw_random t=%0d got %h want %h", t, io.sw_sync, val);
         end
      end
   endtask

   task automatic test_simul_reset();
      int p0 = 0;
      int p1 = 0;
      io.buttons_raw = 2'b00;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         checks++;
         if (io.btn_pulse !== ((c == 6) ? 2'b11 : 2'b00) || io.btn_level !== m_level) begin
            failures++;
            $display("FAIL simul_press edge=%0d got lvl=%b pls=%b want lvl=%b pls=%b", c, io.btn_level, io.btn_pulse, m_level, (c == 6) ? 2'b11 : 2'b00);
         end
      end
      io.buttons_raw = 2'b11;
      repeat (10) @(negedge clk);
      io.buttons_raw = 2'b00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (io.btn_level !== 2'b00 || io.btn_pulse !== 2'b00 || io.sw_sync !== 10'h000) begin
         failures++;
         $display("FAIL reset_async got lvl=%b pls=%b sw=%h want 0", io.btn_level, io.btn_pulse, io.sw_sync);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (io.btn_pulse[0]) p0++;
         if (io.btn_pulse[1]) p1++;
         checks++;
         if (io.btn_pulse !== ((c == 6) ? 2'b11 : 2'b00) || io.btn_level !== ((c >= 6) ? 2'b11 : 2'b00)) begin
            failures++;
            $display("FAIL reset_held edge=%0d got lvl=%b pls=%b want lvl=%b pls=%b", c, io.btn_level, io.btn_pulse, (c >= 6) ? 2'b11 : 2'b00, (c == 6) ? 2'b11 : 2'b00);
         end
      end
      checks++;
      if (p0 != 1 || p1 != 1) begin
         failures++;
         $display("FAIL reset_held_count got p0=%0d p1=%0d want 1 1", p0, p1);
      end
      io.buttons_raw = 2'b11;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_random();
      int hold;
      for (int t = 0; t < 80; t++) begin
         io.buttons_raw = BTN_W'($urandom);
         if ($urandom_range(0, 3) == 0) io.switches_raw = SW_W'($urandom);
         hold = int'($urandom_range(1, 9));
         repeat (hold) begin
            @(negedge clk);
            checks++;
            if (io.btn_level !== m_level || io.btn_pulse !== m_pulse || io.sw_sync !== m_sw) begin
               failures++;
               $display("FAIL random t=%0d got lvl=%b pls=%b sw=%h want lvl=%b pls=%b sw=%h", t, io.btn_level, io.btn_pulse, io.sw_sync, m_level, m_pulse, m_sw);
            end
         end
      end
   endtask

   initial begin
      io.buttons_raw  = 2'b11;
      io.switches_raw = '0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_glitch();
      test_switches();
      test_simul_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_board_input_conditioner

// File: doc/board_input_conditioner.md
# board_input_conditioner

Conditions the raw DE-board inputs before they reach the MIPS top level. It double-flop synchronizes the 10 slide switches and the 2 push buttons. It debounces each button with a per-button counter FSM. It produces a clean level and a single-cycle press pulse per button, which drive the processor's input-port load and run/reset controls. The block sits between the board pins and the `buttons`/`switches` inputs of the processor top level.

## Interface
- `SW_WIDTH`, 10, number of slide switches.
- `BTN_WIDTH`, 2, number of push buttons.
- `DEBOUNCE_CYCLES`, 500000, cycles a synchronized button must be stable before a change is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `BTN_ACTIVE_LOW`, 1, when 1 a raw button reads 0 while pressed.
- `clk`  in  1  system clock; all flops rise-edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low (`rst` low = reset).
- `buttons_raw`  in  BTN_WIDTH  raw push-button pins, asynchronous to `clk`.
- `switches_raw`  in  SW_WIDTH  raw slide-switch pins, asynchronous to `clk`.
- `btn_level`  out  BTN_WIDTH  debounced button state, 1 = pressed (polarity normalized).
- `btn_pulse`  out  BTN_WIDTH  1-cycle pulse on each accepted press.
- `sw_sync`  out  SW_WIDTH  synchronized switches (no debounce).

## Operation
- Switches: 2-flop synchronizer per bit; `sw_sync` is the second stage.
- Buttons: 2-flop synchronizer per bit, then polarity normalization (`active = sync ^ BTN_ACTIVE_LOW`), then an independent debounce FSM per button.
- Debounce FSM states:
  - IDLE (level 0): when active, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: when inactive, go to IDLE and set cnt=0. When active and cnt==DEBOUNCE_CYCLES-1, go to PRESSED. Otherwise cnt++.
  - PRESSED (level 1): when inactive, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT: when active, go to PRESSED and set cnt=0. When inactive and cnt==DEBOUNCE_CYCLES-1, go to IDLE. Otherwise cnt++.
- `btn_level` = 1 in PRESSED and RELEASE_WAIT, 0 otherwise. It is a registered FSM decode and has no glitches.
- `btn_pulse` is registered. It is 1 for exactly the cycle after the PRESS_WAIT→PRESSED transition edge, i.e. it coincides with the first cycle of `btn_level`=1. No pulse is generated on release. No auto-repeat while the button is held.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps: it is cleared on every state change and saturates by transition.
- Buttons are fully independent. Simultaneous presses give simultaneous pulses.
- Reset (async assert, `rst` low):
  - Synchronizer flops take the inactive pin value (1 if BTN_ACTIVE_LOW, else 0); switch synchronizer flops take 0.
  - FSMs go to IDLE and counters to 0.
  - Outputs: `btn_level`=0, `btn_pulse`=0, `sw_sync`=0.
  - Reset mid-count discards the partial count.
  - Reset while a button is held: after release of reset, the held button goes through a full PRESS_WAIT and then produces one pulse.

## Timing
- Edge 0 is the first rising edge that samples a new raw value.
- Switch latency: `sw_sync` updates after edge 1.
- Button press latency: `btn_level` and `btn_pulse` rise after edge DEBOUNCE_CYCLES+2, provided the raw input is stable throughout. `btn_pulse` falls after edge DEBOUNCE_CYCLES+3.
- Release latency: `btn_level` falls after edge DEBOUNCE_CYCLES+2.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles is rejected and does not change `btn_level`.
- Reset deassertion is used directly as an asynchronous-assert flop reset. Reset-release synchronization is owned by the top level.

## Structure
- Package `mips_io_pkg` holds the `debounce_state_t` enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) and the default debounce constant.
- Sub-module `button_debounce` contains one synchronizer, the FSM and the counter for a single button. It is instantiated BTN_WIDTH times by a generate loop.
- The switch synchronizer stays inline in the top of this block.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and BTN_ACTIVE_LOW=1.
- Reset: hold `rst`=0 with random pins → all outputs 0. Release `rst` with buttons=2'b11 → outputs stay 0.
- Clean press: `buttons_raw[0]` goes 1→0 at edge 0 → `btn_level[0]` and `btn_pulse[0]`=1 after edge 6, `btn_pulse[0]`=0 after edge 7. `btn_level[0]` stays 1 while held for 50 cycles, with exactly one pulse.
- Bounce: toggle `buttons_raw[1]` every 2 cycles for 20 cycles, then hold at 0 → exactly one pulse, 6 edges after the final transition. Release with bounce → `btn_level[1]` falls once, no pulse.
- Glitch rejection: drive `buttons_raw[0]`=0 for 3 cycles, then back to 1 → `btn_level` stays 0 and no pulse.
- Switches: `switches_raw`=10'h2A5 at edge 0 → `sw_sync`=10'h2A5 after edge 1; no change after edge 0.
- Simultaneous press and reset: press both buttons at the same edge → both pulses in the same cycle. Assert `rst` mid-PRESS_WAIT on a second press → outputs 0 immediately. After release with the buttons held → one pulse per button, 6 edges later.
